// File: rtl/xyolo_read_nch.sv
// xyolo_read_nch: multi-channel ping-pong weight/bias reader.
// A run fetches LEN beats per active channel over one shared databus into
// that channel's write bank. At the same time it streams the previously
// filled read bank out as DATAPATH_W lanes, with the captured per-channel bias.
//
// Handshake: databus_valid is raised in REQ with databus_addr held stable;
// a beat transfers (and databus_rdata is taken) on any cycle where
// databus_valid and databus_ready are both high. flow_out_valid qualifies
// flow_out_weight for exactly one cycle per streamed word.
module xyolo_read_nch #(
   parameter int N_CH        = 4,
   parameter int DATAPATH_W  = 32,
   parameter int DATABUS_W   = 256,
   parameter int ADDR_W      = 32,
   parameter int BUF_ADDR_W  = 9,
   parameter int LEN_W       = 8,
   parameter int CONF_ADDR_W = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       run,
   output logic                       done,
   input  logic                       valid,
   input  logic [CONF_ADDR_W-1:0]     addr,
   input  logic [ADDR_W-1:0]          wdata,
   input  logic                       wstrb,
   output logic                       databus_valid,
   input  logic                       databus_ready,
   output logic [ADDR_W-1:0]          databus_addr,
   input  logic [DATABUS_W-1:0]       databus_rdata,
   output logic [DATABUS_W-1:0]       databus_wdata,
   output logic [DATABUS_W/8-1:0]     databus_wstrb,
   output logic [LEN_W-1:0]           dma_len,
   output logic [N_CH*DATAPATH_W-1:0] flow_out_weight,
   output logic [N_CH*DATAPATH_W-1:0] flow_out_bias,
   output logic                       flow_out_valid
);

   localparam int BYTES  = DATABUS_W / 8;
   localparam int LANES  = DATABUS_W / DATAPATH_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int NACT_W = $clog2(N_CH + 1);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int DEPTH  = 1 << BUF_ADDR_W;

   typedef enum logic [1:0] {F_IDLE, F_REQ, F_FIN} fstate_t;

   // configuration registers
   logic [ADDR_W-1:0] cfg_ext, cfg_stride, cfg_rd_cnt;
   logic [LEN_W-1:0]  cfg_len;
   logic [NACT_W-1:0] cfg_n_act, n_act_clamped;
   logic              cfg_bias_en;

   // run shadows and banks
   logic [ADDR_W-1:0] sh_ext, sh_stride, sh_rd_cnt;
   logic [LEN_W-1:0]  sh_len;
   logic [NACT_W-1:0] sh_n_act;
   logic              sh_bias_en;
   logic              wbank, rbank;

   // fetch FSM
   fstate_t           state;
   logic [NACT_W-1:0] ch;
   logic [LEN_W-1:0]  beat;
   logic [ADDR_W-1:0] ch_base, beat_off;
   logic              beat_xfer, start;

   // storage
   logic [DATABUS_W-1:0]  mem [N_CH][2][DEPTH];
   logic [DATAPATH_W-1:0] bias_mem [N_CH][2];
   logic [DATABUS_W-1:0]  mem_q [N_CH];

   // streamer
   logic                      s_active, p1_valid;
   logic [ADDR_W-1:0]         r;
   logic [LANE_W-1:0]         p1_lane, r_lane;
   logic [BUF_ADDR_W-1:0]     rd_word;
   logic [N_CH*DATAPATH_W-1:0] weight_next;

   assign start         = run & done;
   assign beat_xfer     = (state == F_REQ) & databus_ready;
   assign databus_valid = (state == F_REQ);
   assign databus_addr  = (state == F_REQ) ? (ch_base + beat_off) : '0;
   assign databus_wdata = '0;
   assign databus_wstrb = '0;
   assign dma_len       = (sh_len == '0) ? '0 : sh_len - LEN_W'(1);
   assign done          = (state == F_IDLE) & ~s_active & ~p1_valid & ~flow_out_valid;
   assign rd_word       = BUF_ADDR_W'(r / ADDR_W'(LANES));
   assign r_lane        = LANE_W'(r % ADDR_W'(LANES));

   // N_ACT writes are clamped into 1..N_CH
   always_comb begin
      n_act_clamped = wdata[NACT_W-1:0];
      if (wdata == '0)
         n_act_clamped = NACT_W'(1);
      else if (wdata > ADDR_W'(N_CH))
         n_act_clamped = NACT_W'(N_CH);
   end

   // config register file; clear zeroes it like reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_ext <= '0; cfg_stride <= '0; cfg_len <= '0;
         cfg_n_act <= NACT_W'(1); cfg_rd_cnt <= '0; cfg_bias_en <= 1'b0;
      end else if (clear) begin
         cfg_ext <= '0; cfg_stride <= '0; cfg_len <= '0;
         cfg_n_act <= NACT_W'(1); cfg_rd_cnt <= '0; cfg_bias_en <= 1'b0;
      end else if (valid && wstrb) begin
         case (addr)
            CONF_ADDR_W'(0): cfg_ext     <= wdata;
            CONF_ADDR_W'(1): cfg_stride  <= wdata;
            CONF_ADDR_W'(2): cfg_len     <= wdata[LEN_W-1:0];
            CONF_ADDR_W'(3): cfg_n_act   <= n_act_clamped;
            CONF_ADDR_W'(4): cfg_rd_cnt  <= wdata;
            CONF_ADDR_W'(5): cfg_bias_en <= wdata[0];
            default: ;
         endcase
      end
   end

   // shadow latch, bank swap and fetch FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_ext <= '0; sh_stride <= '0; sh_len <= '0; sh_n_act <= NACT_W'(1);
         sh_rd_cnt <= '0; sh_bias_en <= 1'b0; wbank <= 1'b0; rbank <= 1'b0;
         state <= F_IDLE; ch <= '0; beat <= '0; ch_base <= '0; beat_off <= '0;
      end else if (start) begin
         sh_ext <= cfg_ext; sh_stride <= cfg_stride; sh_len <= cfg_len;
         sh_n_act <= cfg_n_act; sh_rd_cnt <= cfg_rd_cnt; sh_bias_en <= cfg_bias_en;
         // an empty previous run left its write bank untouched, so keep it
         wbank <= (sh_len != '0) ? ~wbank : wbank;
         rbank <= (sh_len != '0) ? wbank : ~wbank;
         state <= (cfg_len == '0) ? F_FIN : F_REQ;
         ch <= '0; beat <= '0; ch_base <= cfg_ext; beat_off <= '0;
      end else begin
         case (state)
            F_REQ: if (databus_ready) begin
               if (beat == sh_len - LEN_W'(1)) begin
                  beat <= '0;
                  beat_off <= '0;
                  if (ch == sh_n_act - NACT_W'(1)) begin
                     state <= F_FIN;
                  end else begin
                     ch <= ch + NACT_W'(1);
                     ch_base <= ch_base + sh_stride;
                  end
               end else begin
                  beat <= beat + LEN_W'(1);
                  beat_off <= beat_off + ADDR_W'(BYTES);
               end
            end
            F_FIN: state <= F_IDLE;
            default: ;
         endcase
      end
   end

   // bias capture from lane 0 of each channel's first beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++) begin
            bias_mem[c][0] <= '0;
            bias_mem[c][1] <= '0;
         end
      end else if (beat_xfer && sh_bias_en && beat == '0) begin
         bias_mem[CH_W'(ch)][wbank] <= databus_rdata[DATAPATH_W-1:0];
      end
   end

   // ping-pong buffer write port and registered read of the read bank
   always_ff @(posedge clk) begin
      if (beat_xfer)
         mem[CH_W'(ch)][wbank][BUF_ADDR_W'(beat)] <= databus_rdata;
      for (int c = 0; c < N_CH; c++)
         mem_q[c] <= mem[c][rbank][rd_word];
   end

   // lane select with inactive channels forced to zero
   always_comb begin
      weight_next = '0;
      for (int c = 0; c < N_CH; c++)
         if (NACT_W'(c) < sh_n_act)
            weight_next[(N_CH-1-c)*DATAPATH_W +: DATAPATH_W] =
               mem_q[c][32'(p1_lane)*DATAPATH_W +: DATAPATH_W];
   end

   // read-bank bias, channel 0 in the MSBs
   always_comb begin
      flow_out_bias = '0;
      for (int c = 0; c < N_CH; c++)
         if (NACT_W'(c) < sh_n_act)
            flow_out_bias[(N_CH-1-c)*DATAPATH_W +: DATAPATH_W] = bias_mem[c][rbank];
   end

   // streamer: issue counter, read pipeline stage, output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_active <= 1'b0; r <= '0; p1_valid <= 1'b0; p1_lane <= '0;
         flow_out_valid <= 1'b0; flow_out_weight <= '0;
      end else begin
         if (start) begin
            s_active <= (cfg_rd_cnt != '0);
            r <= '0;
         end else if (s_active) begin
            r <= r + ADDR_W'(1);
            if (r == sh_rd_cnt - ADDR_W'(1))
               s_active <= 1'b0;
         end
         p1_valid <= s_active;
         p1_lane <= r_lane;
         flow_out_valid <= p1_valid;
         if (p1_valid)
            flow_out_weight <= weight_next;
      end
   end

endmodule

// File: tb/tb_xyolo_read_nch.sv
// Bench for xyolo_read_nch: directed runs against a scoreboard of expected
// databus addresses and streamed weight vectors.
module tb_xyolo_read_nch;

   localparam int N_CH = 4;
   localparam int DW   = 32;
   localparam int BW   = 256;
   localparam int AW   = 32;

   logic            clk, rst, clear, run, done;
   logic            valid, wstrb;
   logic [2:0]      addr;
   logic [AW-1:0]   wdata;
   logic            databus_valid, databus_ready;
   logic [AW-1:0]   databus_addr;
   logic [BW-1:0]   databus_rdata, databus_wdata;
   logic [BW/8-1:0] databus_wstrb;
   logic [7:0]      dma_len;
   logic [N_CH*DW-1:0] flow_out_weight, flow_out_bias;
   logic            flow_out_valid;

   int checks = 0;
   int errors = 0;
   logic            stall_mode = 1'b0;
   logic [AW-1:0]   addr_q[$];
   logic [N_CH*DW-1:0] flow_q[$];
   logic            prev_stall = 1'b0;
   logic [AW-1:0]   prev_addr = '0;
   int              done_k, first_v;

   xyolo_read_nch dut (
      .clk(clk), .rst(rst), .clear(clear), .run(run), .done(done),
      .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .databus_valid(databus_valid), .databus_ready(databus_ready),
      .databus_addr(databus_addr), .databus_rdata(databus_rdata),
      .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb),
      .dma_len(dma_len), .flow_out_weight(flow_out_weight),
      .flow_out_bias(flow_out_bias), .flow_out_valid(flow_out_valid)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   // memory pattern: lane 0 of a 256-byte aligned beat carries 0xC0DE000n
   function automatic logic [DW-1:0] gen_word(input logic [AW-1:0] a, input int j);
      if (j == 0 && a[7:0] == 8'h00)
         return 32'hC0DE0000 | {28'h0, a[11:8]};
      return {a[23:0], 8'(j)};
   endfunction

   function automatic logic [BW-1:0] gen_beat(input logic [AW-1:0] a);
      logic [BW-1:0] b;
      for (int j = 0; j < BW/DW; j++) b[j*DW +: DW] = gen_word(a, j);
      return b;
   endfunction

   function automatic logic [N_CH*DW-1:0] exp_flow(input logic [AW-1:0] ext,
         input logic [AW-1:0] stride, input int n_act, input int r);
      logic [N_CH*DW-1:0] v;
      v = '0;
      for (int c = 0; c < N_CH; c++)
         if (c < n_act)
            v[(N_CH-1-c)*DW +: DW] = gen_word(ext + c*stride + (r/8)*32, r % 8);
      return v;
   endfunction

   assign databus_rdata = gen_beat(databus_addr);

   // ready driver
   initial begin
      databus_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         databus_ready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   task automatic chk(input string name, input logic [N_CH*DW-1:0] act,
                      input logic [N_CH*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a beat or word
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && databus_valid)
            chk("addr_hold", databus_addr, prev_addr);
         if (databus_valid && databus_ready) begin
            if (addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL addr_extra act=%h exp=none", databus_addr);
            end else begin
               chk("databus_addr", databus_addr, addr_q.pop_front());
            end
         end
         if (flow_out_valid) begin
            if (flow_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL flow_extra act=%h exp=none", flow_out_weight);
            end else begin
               chk("flow_out_weight", flow_out_weight, flow_q.pop_front());
            end
         end
         prev_stall <= databus_valid && !databus_ready;
         prev_addr <= databus_addr;
      end
   end

   // driver tasks
   task automatic write_cfg(input logic [2:0] a, input logic [AW-1:0] d);
      @(posedge clk); #1;
      valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      valid = 1'b0; wstrb = 1'b0;
   endtask

   task automatic cfg_all(input logic [AW-1:0] ext, input logic [AW-1:0] stride,
         input int len, input int n_act, input int rd_cnt, input int bias_en);
      write_cfg(3'd0, ext);
      write_cfg(3'd1, stride);
      write_cfg(3'd2, AW'(len));
      write_cfg(3'd3, AW'(n_act));
      write_cfg(3'd4, AW'(rd_cnt));
      write_cfg(3'd5, AW'(bias_en));
   endtask

   task automatic push_exp(input logic [AW-1:0] ext, input logic [AW-1:0] stride,
         input int len, input int n_fetch, input int rd_cnt,
         input logic [AW-1:0] src_ext, input int n_stream);
      for (int c = 0; c < n_fetch; c++)
         for (int b = 0; b < len; b++)
            addr_q.push_back(ext + c*stride + b*32);
      for (int r = 0; r < rd_cnt; r++)
         flow_q.push_back(exp_flow(src_ext, 32'h100, n_stream, r));
   endtask

   // pulse run, then time done/first valid relative to the run edge
   task automatic do_run(input int extra_run_at, input int clear_at,
                         output int d_k, output int f_v);
      d_k = -1; f_v = -1;
      @(posedge clk); #1 run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (flow_out_valid && f_v < 0) f_v = k;
         if (done) begin d_k = k; break; end
         run = (k == extra_run_at);
         clear = (k == clear_at);
      end
      run = 1'b0; clear = 1'b0;
      if (d_k < 0) begin
         checks++; errors++;
         $display("FAIL run_timeout act=busy exp=done");
      end
   endtask

   task automatic chk_empty(input string name);
      chk({name, "_addr_left"}, N_CH*DW'(addr_q.size()), '0);
      chk({name, "_flow_left"}, N_CH*DW'(flow_q.size()), '0);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; run = 1'b0; valid = 1'b0; wstrb = 1'b0;
      addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", done, 1'b1);
      chk("rst_dbvalid", databus_valid, 1'b0);
      chk("rst_dbaddr", databus_addr, '0);
      chk("rst_fvalid", flow_out_valid, 1'b0);
      chk("rst_weight", flow_out_weight, '0);
      chk("rst_bias", flow_out_bias, '0);
      chk("rst_dma_len", dma_len, '0);
      chk("rst_wdata", databus_wdata[N_CH*DW-1:0], '0);
      chk("rst_wstrb", databus_wstrb, '0);
      @(negedge clk) rst = 1'b0;

      // A: fill bank 0, four channels, two beats each, bias captured
      cfg_all(32'h1000, 32'h100, 2, 4, 0, 1);
      push_exp(32'h1000, 32'h100, 2, 4, 0, 32'h0, 4);
      do_run(-1, -1, done_k, first_v);
      chk("A_done_k", done_k, 9);
      chk("A_dma_len", dma_len, 8'd1);
      chk("A_bias", flow_out_bias, '0);
      chk_empty("A");

      // B: stream bank 0 while filling bank 1; clear mid-run
      cfg_all(32'h2000, 32'h100, 2, 4, 16, 1);
      push_exp(32'h2000, 32'h100, 2, 4, 16, 32'h1000, 4);
      do_run(-1, 3, done_k, first_v);
      chk("B_done_k", done_k, 18);
      chk("B_first_valid", first_v, 2);
      chk("B_bias", flow_out_bias, {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003});
      chk_empty("B");

      // C: fill bank 0 under random ready stalls, stream bank 1
      stall_mode = 1'b1;
      cfg_all(32'h2800, 32'h100, 2, 4, 16, 0);
      push_exp(32'h2800, 32'h100, 2, 4, 16, 32'h2000, 4);
      do_run(-1, -1, done_k, first_v);
      stall_mode = 1'b0;
      chk("C_first_valid", first_v, 2);
      chk_empty("C");

      // D: stream the stalled fill back out
      cfg_all(32'h3000, 32'h100, 2, 4, 16, 0);
      push_exp(32'h3000, 32'h100, 2, 4, 16, 32'h2800, 4);
      do_run(-1, -1, done_k, first_v);
      chk("D_done_k", done_k, 18);
      chk("D_bias", flow_out_bias, {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003});
      chk_empty("D");

      // E: no fetch, two active channels, four words
      cfg_all(32'h3400, 32'h100, 0, 2, 4, 0);
      push_exp(32'h3400, 32'h100, 0, 2, 4, 32'h3000, 2);
      do_run(-1, -1, done_k, first_v);
      chk("E_done_k", done_k, 6);
      chk("E_dma_len", dma_len, 8'd0);
      chk("E_bias", flow_out_bias, {32'hC0DE0000, 32'hC0DE0001, 64'h0});
      chk_empty("E");

      // F: previous run was empty, so the same read bank streams again; N_ACT=9 clamps to 4
      cfg_all(32'h0, 32'h100, 0, 9, 4, 0);
      push_exp(32'h0, 32'h100, 0, 4, 4, 32'h3000, 4);
      do_run(-1, -1, done_k, first_v);
      chk("F_done_k", done_k, 6);
      chk("F_bias", flow_out_bias, {32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003});
      chk_empty("F");

      // G: run pulsed while busy is ignored
      cfg_all(32'h4000, 32'h100, 2, 4, 0, 0);
      push_exp(32'h4000, 32'h100, 2, 4, 0, 32'h0, 4);
      do_run(3, -1, done_k, first_v);
      chk("G_done_k", done_k, 9);
      chk_empty("G");

      // H: clear zeroes config, so the next run does nothing
      cfg_all(32'h4000, 32'h100, 2, 4, 8, 1);
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      do_run(-1, -1, done_k, first_v);
      chk("H_done_k", done_k, 1);
      chk("H_dma_len", dma_len, 8'd0);
      chk_empty("H");

      // I: reset in the middle of a burst
      cfg_all(32'h5000, 32'h100, 2, 4, 8, 1);
      push_exp(32'h5000, 32'h100, 2, 4, 8, 32'h3000, 4);
      @(posedge clk); #1 run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("I_busy_before_rst", databus_valid, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("I_rst_dbvalid", databus_valid, 1'b0);
      chk("I_rst_done", done, 1'b1);
      chk("I_rst_fvalid", flow_out_valid, 1'b0);
      chk("I_rst_weight", flow_out_weight, '0);
      chk("I_rst_bias", flow_out_bias, '0);
      chk("I_rst_dma_len", dma_len, '0);
      addr_q.delete();
      flow_q.delete();
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("I_after_dbvalid", databus_valid, 1'b0);
      chk("I_after_done", done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
